// File: rtl/pom_twinfo_arb_pkg.sv
// Shared definitions for the task-wait info memory arbiter.
//   TW_INFO_BITS_DEF : default byte-address width of the task-wait info memory
//   TW_INFO_STRIDE   : bytes per entry (one 128-bit word)
//   arb_state_e      : arbiter FSM encoding
//   owner_e          : identity of the last port owner, used for round-robin
package pom_twinfo_arb_pkg;

  localparam int TW_INFO_BITS_DEF = 8;
  localparam int TW_INFO_STRIDE   = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_OWN_A = 2'd1,
    ST_OWN_B = 2'd2
  } arb_state_e;

  typedef enum logic {
    OWNER_A = 1'b0,
    OWNER_B = 1'b1
  } owner_e;

endpackage

// File: rtl/pom_twinfo_arb.sv
// Two-master arbiter for the single-port task-wait info memory.
// Master A is the gateway, master B is the taskwait/finish updater. A master
// requests the port with x_req and, once granted, keeps it for as long as
// x_req stays high (locked burst), so read-modify-write and search sequences
// are atomic. Ties in IDLE go round-robin against the last owner.
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   x_req/x_gnt                   ownership request / registered grant
//   x_en/x_we/x_addr/x_din        access strobe, byte enables, address, data
//   x_rvalid                      read data on rdata is valid for master x
//   x_err                         sticky: master x strobed en without grant
//   rdata                         memory read data, broadcast to both masters
//   tw_info_*                     memory port (1-cycle read latency)
module pom_twinfo_arb
  import pom_twinfo_arb_pkg::*;
#(
  parameter int TW_INFO_BITS = TW_INFO_BITS_DEF,
  parameter int TW_INFO_SIZE = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  // gateway
  input  logic                    a_req,
  output logic                    a_gnt,
  input  logic                    a_en,
  input  logic [15:0]             a_we,
  input  logic [TW_INFO_BITS-1:0] a_addr,
  input  logic [127:0]            a_din,
  output logic                    a_rvalid,
  output logic                    a_err,
  // taskwait/finish updater
  input  logic                    b_req,
  output logic                    b_gnt,
  input  logic                    b_en,
  input  logic [15:0]             b_we,
  input  logic [TW_INFO_BITS-1:0] b_addr,
  input  logic [127:0]            b_din,
  output logic                    b_rvalid,
  output logic                    b_err,
  // shared read data
  output logic [127:0]            rdata,
  // memory port
  output logic                    tw_info_clk,
  output logic                    tw_info_en,
  output logic [15:0]             tw_info_we,
  output logic [31:0]             tw_info_addr,
  output logic [127:0]            tw_info_din,
  input  logic [127:0]            tw_info_dout
);

  // Addresses are not range-checked: anything the master drives goes to the
  // memory. This block only records the configuration where the entry array
  // would not fit in the address space.
  if (TW_INFO_SIZE * TW_INFO_STRIDE > (1 << TW_INFO_BITS)) begin : g_size_exceeds_addr
  end

  arb_state_e state_q, state_d;
  owner_e     last_owner_q, last_owner_d;
  logic       a_rvalid_q, b_rvalid_q;
  logic       a_err_q, b_err_q;
  logic       own_a, own_b;
  logic [TW_INFO_BITS-1:0] addr_sel;

  // Grants are pure state decodes so they never glitch with req.
  assign own_a = (state_q == ST_OWN_A);
  assign own_b = (state_q == ST_OWN_B);

  always_comb begin
    state_d      = state_q;
    last_owner_d = last_owner_q;
    case (state_q)
      ST_IDLE: begin
        if (a_req && b_req)
          state_d = (last_owner_q == OWNER_B) ? ST_OWN_A : ST_OWN_B;
        else if (a_req)
          state_d = ST_OWN_A;
        else if (b_req)
          state_d = ST_OWN_B;
      end
      // Dropping req releases straight to IDLE; the IDLE cycle is the
      // turnaround before the next grant.
      ST_OWN_A: begin
        if (!a_req) begin
          state_d      = ST_IDLE;
          last_owner_d = OWNER_A;
        end
      end
      ST_OWN_B: begin
        if (!b_req) begin
          state_d      = ST_IDLE;
          last_owner_d = OWNER_B;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Only the owner reaches the memory; a non-owner's en/we is dropped here.
  always_comb begin
    tw_info_en  = 1'b0;
    tw_info_we  = '0;
    addr_sel    = '0;
    tw_info_din = '0;
    if (own_a) begin
      tw_info_en  = a_en;
      tw_info_we  = a_we;
      addr_sel    = a_addr;
      tw_info_din = a_din;
    end else if (own_b) begin
      tw_info_en  = b_en;
      tw_info_we  = b_we;
      addr_sel    = b_addr;
      tw_info_din = b_din;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      last_owner_q <= OWNER_B;   // A wins the first tie
      a_rvalid_q   <= 1'b0;
      b_rvalid_q   <= 1'b0;
      a_err_q      <= 1'b0;
      b_err_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_owner_q <= last_owner_d;
      // Based on the current owner, so a read in the releasing cycle still
      // returns its valid during the turnaround cycle.
      a_rvalid_q   <= own_a && a_en && (a_we == '0);
      b_rvalid_q   <= own_b && b_en && (b_we == '0);
      a_err_q      <= a_err_q | (a_en && !own_a);
      b_err_q      <= b_err_q | (b_en && !own_b);
    end
  end

  assign a_gnt        = own_a;
  assign b_gnt        = own_b;
  assign a_rvalid     = a_rvalid_q;
  assign b_rvalid     = b_rvalid_q;
  assign a_err        = a_err_q;
  assign b_err        = b_err_q;
  assign rdata        = tw_info_dout;
  assign tw_info_clk  = clk;
  assign tw_info_addr = 32'(addr_sel);

endmodule

// File: tb/tb_pom_twinfo_arb.sv
// Self-checking bench for pom_twinfo_arb: a behavioural 16x128 memory with
// 1-cycle read latency, a read scoreboard per master, a table of request
// patterns for arbitration, and directed multi-cycle sequences.
module tb_pom_twinfo_arb;

  localparam int TWB = 8;

  logic           clk = 1'b0;
  logic           rst;
  logic           a_req, a_gnt, a_en, a_rvalid, a_err;
  logic [15:0]    a_we;
  logic [TWB-1:0] a_addr;
  logic [127:0]   a_din;
  logic           b_req, b_gnt, b_en, b_rvalid, b_err;
  logic [15:0]    b_we;
  logic [TWB-1:0] b_addr;
  logic [127:0]   b_din;
  logic [127:0]   rdata;
  logic           tw_info_clk, tw_info_en;
  logic [15:0]    tw_info_we;
  logic [31:0]    tw_info_addr;
  logic [127:0]   tw_info_din, tw_info_dout;

  always #5 clk = ~clk;

  pom_twinfo_arb #(.TW_INFO_BITS(TWB), .TW_INFO_SIZE(16)) dut (
    .clk(clk), .rst(rst),
    .a_req(a_req), .a_gnt(a_gnt), .a_en(a_en), .a_we(a_we), .a_addr(a_addr),
    .a_din(a_din), .a_rvalid(a_rvalid), .a_err(a_err),
    .b_req(b_req), .b_gnt(b_gnt), .b_en(b_en), .b_we(b_we), .b_addr(b_addr),
    .b_din(b_din), .b_rvalid(b_rvalid), .b_err(b_err),
    .rdata(rdata),
    .tw_info_clk(tw_info_clk), .tw_info_en(tw_info_en), .tw_info_we(tw_info_we),
    .tw_info_addr(tw_info_addr), .tw_info_din(tw_info_din),
    .tw_info_dout(tw_info_dout)
  );

  // Memory model driven only by the arbiter's memory port.
  logic [127:0] mem [16];
  logic [127:0] exp_mem [16];
  logic         mem_init;

  function automatic logic [127:0] init_word(int i);
    return {4{32'hC0DE_0000 + 32'(i)}};
  endfunction

  always @(posedge tw_info_clk) begin
    if (mem_init) begin
      for (int i = 0; i < 16; i++) mem[i] <= init_word(i);
    end else if (tw_info_en) begin
      for (int j = 0; j < 16; j++)
        if (tw_info_we[j]) mem[tw_info_addr[7:4]][8*j +: 8] <= tw_info_din[8*j +: 8];
      tw_info_dout <= mem[tw_info_addr[7:4]];
    end
  end

  int checks = 0;
  int failures = 0;
  logic [127:0] qa[$], qb[$];

  task automatic chk(string name, logic [127:0] act, logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Advance one clock, then check read returns against the scoreboard.
  task automatic step();
    logic         ea, eb;
    logic [127:0] da, db;
    @(posedge clk);
    #1;
    ea = (qa.size() != 0);
    eb = (qb.size() != 0);
    da = ea ? qa.pop_front() : '0;
    db = eb ? qb.pop_front() : '0;
    chk("a_rvalid", a_rvalid, ea);
    chk("b_rvalid", b_rvalid, eb);
    if (ea && a_rvalid) chk("a_rdata", rdata, da);
    if (eb && b_rvalid) chk("b_rdata", rdata, db);
  endtask

  task automatic drv_a(logic en, logic [15:0] we, logic [7:0] addr, logic [127:0] din);
    a_en = en; a_we = we; a_addr = addr; a_din = din;
  endtask

  task automatic drv_b(logic en, logic [15:0] we, logic [7:0] addr, logic [127:0] din);
    b_en = en; b_we = we; b_addr = addr; b_din = din;
  endtask

  task automatic rd_a(logic [7:0] addr);
    drv_a(1'b1, 16'h0000, addr, '0);
    qa.push_back(exp_mem[addr[7:4]]);
  endtask

  typedef struct {
    logic a_req;
    logic b_req;
    logic a_gnt;
    logic b_gnt;
  } arb_vec_t;

  arb_vec_t tbl [18];

  initial begin
    int pulses;
    logic [127:0] da, db;

    // row: drive reqs, clock once, expect grants
    tbl[0]  = '{1'b1, 1'b1, 1'b1, 1'b0};  // tie after reset -> A
    tbl[1]  = '{1'b1, 1'b1, 1'b1, 1'b0};
    tbl[2]  = '{1'b1, 1'b1, 1'b1, 1'b0};
    tbl[3]  = '{1'b1, 1'b1, 1'b1, 1'b0};
    tbl[4]  = '{1'b1, 1'b1, 1'b1, 1'b0};
    tbl[5]  = '{1'b0, 1'b1, 1'b0, 1'b0};  // A drops -> IDLE turnaround
    tbl[6]  = '{1'b0, 1'b1, 1'b0, 1'b1};  // B granted
    tbl[7]  = '{1'b1, 1'b1, 1'b0, 1'b1};  // B locked while A waits
    tbl[8]  = '{1'b1, 1'b0, 1'b0, 1'b0};  // B releases
    tbl[9]  = '{1'b1, 1'b1, 1'b1, 0};     // tie, last owner B -> A
    tbl[10] = '{1'b0, 1'b1, 1'b0, 1'b0};  // A releases, both still wanting next
    tbl[11] = '{1'b1, 1'b1, 1'b0, 1'b1};  // tie, last owner A -> B
    tbl[12] = '{1'b1, 1'b0, 1'b0, 1'b0};
    tbl[13] = '{1'b1, 1'b1, 1'b1, 1'b0};  // tie, last owner B -> A
    tbl[14] = '{1'b0, 1'b0, 1'b0, 1'b0};
    tbl[15] = '{1'b0, 1'b0, 1'b0, 1'b0};  // stays idle
    tbl[16] = '{1'b0, 1'b1, 1'b0, 1'b1};  // lone B
    tbl[17] = '{1'b0, 1'b0, 1'b0, 1'b0};

    for (int i = 0; i < 16; i++) exp_mem[i] = init_word(i);
    mem_init = 1'b1;
    rst = 1'b1; a_req = 1'b0; b_req = 1'b0;
    drv_a(1'b0, '0, '0, '0);
    drv_b(1'b0, '0, '0, '0);
    step();
    step();
    mem_init = 1'b0;

    // reset state
    chk("rst_a_gnt", a_gnt, 0);
    chk("rst_b_gnt", b_gnt, 0);
    chk("rst_a_err", a_err, 0);
    chk("rst_b_err", b_err, 0);
    chk("rst_en", tw_info_en, 0);
    chk("rst_we", tw_info_we, 0);
    rst = 1'b0;

    // single request, read, write, boundary address, read on release
    a_req = 1'b1;
    step();
    chk("single_a_gnt", a_gnt, 1);
    chk("single_b_gnt", b_gnt, 0);
    rd_a(8'h20);
    #1;
    chk("rd_addr", tw_info_addr, 32'h0000_0020);
    chk("rd_en", tw_info_en, 1);
    chk("rd_we", tw_info_we, 0);
    step();
    da = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
    drv_a(1'b1, 16'hFFFF, 8'h30, da);
    exp_mem[3] = da;
    #1;
    chk("wr_we", tw_info_we, 16'hFFFF);
    chk("wr_din", tw_info_din, da);
    chk("wr_addr", tw_info_addr, 32'h0000_0030);
    step();
    rd_a(8'h30);
    step();
    rd_a(8'hF0);
    #1;
    chk("top_addr", tw_info_addr, 32'h0000_00F0);
    step();
    rd_a(8'h20);
    a_req = 1'b0;
    step();
    chk("release_a_gnt", a_gnt, 0);
    chk("release_en", tw_info_en, 0);
    drv_a(1'b0, '0, '0, '0);
    step();
    chk("single_a_err", a_err, 0);

    // arbitration table from a fresh reset
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int r = 0; r < 18; r++) begin
      a_req = tbl[r].a_req;
      b_req = tbl[r].b_req;
      step();
      chk($sformatf("tbl%0d_a_gnt", r), a_gnt, tbl[r].a_gnt);
      chk($sformatf("tbl%0d_b_gnt", r), b_gnt, tbl[r].b_gnt);
    end

    // locked burst with B requesting and illegal B accesses
    a_req = 1'b1; b_req = 1'b1;
    step();
    chk("burst_a_gnt", a_gnt, 1);
    pulses = 0;
    db = {4{32'hDEAD_BEEF}};
    for (int c = 0; c < 300; c++) begin
      if (c < 16) rd_a(8'(c * 16));
      else if (c == 20) begin
        da = {4{32'h1111_2222}};
        drv_a(1'b1, 16'h000F, 8'h50, da);
        drv_b(1'b1, 16'hFFFF, 8'h50, db);
        exp_mem[5][31:0] = da[31:0];
        #1;
        chk("mix_we", tw_info_we, 16'h000F);
        chk("mix_din", tw_info_din, da);
      end else if (c == 21) begin
        drv_a(1'b0, '0, '0, '0);
        drv_b(1'b1, 16'hFFFF, 8'h60, db);
        #1;
        chk("blk_en", tw_info_en, 0);
        chk("blk_we", tw_info_we, 0);
      end else if (c == 30) begin
        drv_b(1'b0, '0, '0, '0);
        rd_a(8'h50);
      end else if (c == 31) rd_a(8'h60);
      else drv_a(1'b0, '0, '0, '0);
      step();
      if (c < 16 && a_rvalid) pulses++;
      if (c == 20) chk("b_err_set", b_err, 1);
      chk("burst_b_gnt", b_gnt, 0);
      chk("burst_a_gnt_hold", a_gnt, 1);
    end
    chk("burst_pulses", pulses, 16);
    chk("b_err_sticky", b_err, 1);
    chk("burst_a_err", a_err, 0);

    // reset in the middle of A's read
    rd_a(8'h20);
    rst = 1'b1;
    qa.delete();
    step();
    chk("mid_a_gnt", a_gnt, 0);
    chk("mid_b_gnt", b_gnt, 0);
    chk("mid_b_err", b_err, 0);
    chk("mid_a_err", a_err, 0);
    chk("mid_en", tw_info_en, 0);
    drv_a(1'b0, '0, '0, '0);
    rst = 1'b0;
    step();
    chk("post_a_gnt", a_gnt, 1);
    chk("post_b_gnt", b_gnt, 0);
    a_req = 1'b0; b_req = 1'b0;
    step();
    step();
    chk("queue_a_empty", qa.size(), 0);
    chk("queue_b_empty", qb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pom_twinfo_arb.md
POM_TWINFO_ARB -- requirements
Module: pom_twinfo_arb

Interface
REQ-001 SHALL have parameter: TW_INFO_BITS, 8, address width of the task-wait info memory.
REQ-002 SHALL have parameter: TW_INFO_SIZE, 16, number of 16-byte entries.
REQ-003 SHALL have ports (clock and reset first):
- clk  in  1  sole clock; all logic is clocked on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- a_req  in  1  gateway requests ownership of the memory port.
- a_gnt  out  1  gateway owns the port.
- a_en  in  1  gateway access strobe.
- a_we  in  16  gateway byte write enables.
- a_addr  in  TW_INFO_BITS  gateway byte address (16-byte aligned).
- a_din  in  128  gateway write data.
- a_rvalid  out  1  the shared read data is valid for the gateway.
- a_err  out  1  sticky flag: the gateway accessed the port without a grant.
- b_req, b_gnt, b_en, b_we, b_addr, b_din, b_rvalid, b_err  same directions and widths as the a_ ports, for the taskwait/finish updater.
- rdata  out  128  memory read data, broadcast to both masters.
- tw_info_clk  out  1  memory clock, equal to clk.
- tw_info_en  out  1  memory enable.
- tw_info_we  out  16  memory byte write enables.
- tw_info_addr  out  32  memory address, TW_INFO_BITS wide, zero-extended.
- tw_info_din  out  128  memory write data.
- tw_info_dout  in  128  memory read data; 1-cycle read latency.

Function
REQ-004 SHALL implement an FSM with three states: IDLE, OWN_A and OWN_B.
REQ-005 In IDLE, the FSM SHALL move to OWN_A or OWN_B on the next edge, depending on which master has req asserted.
REQ-006 If a_req and b_req are asserted in the same IDLE cycle, the FSM SHALL grant the master that did not own the port last (round-robin), using a last_owner register.
REQ-007 a_gnt SHALL be 1 only in OWN_A, and b_gnt SHALL be 1 only in OWN_B; both grants SHALL be registered state decodes, never combinational from req.
REQ-008 While a master holds its grant and keeps req at 1, the grant SHALL persist for an unlimited number of cycles (locked burst), so that read-modify-write and search sequences are atomic.
REQ-009 Release: when the owning master drops req in OWN_x, the FSM SHALL return to IDLE on that edge and set last_owner to x; the next grant is issued no earlier than one cycle later (one turnaround cycle).
REQ-010 tw_info_en, tw_info_we, tw_info_addr and tw_info_din SHALL be combinational multiplexes of the owner's en, we, addr and din.
REQ-011 In IDLE, tw_info_en SHALL be 0 and tw_info_we SHALL be 0.
REQ-012 Any en or we from a master that does not own the port SHALL be blocked from the memory.
REQ-013 rdata SHALL equal tw_info_dout.
REQ-014 x_rvalid SHALL be registered and SHALL equal 1 exactly one cycle after an owner cycle with x_en=1 and x_we=0.
REQ-015 A read issued in the last owned cycle (req dropped in the same cycle) SHALL still produce x_rvalid in the turnaround cycle.
REQ-016 x_err SHALL be set when x_en=1 while x_gnt=0, and SHALL be cleared only by reset.
REQ-017 A write issued with en=1 and we=FFFF SHALL reach the memory in the same cycle; the arbiter adds no write latency.
REQ-018 tw_info_addr SHALL carry the owner address, TW_INFO_BITS wide, zero-extended to 32 bits; addresses at or above TW_INFO_SIZE*16 SHALL pass through unchecked.

Reset
REQ-019 While rst=1, the arbiter SHALL reset to:
- state = IDLE and last_owner = B, so that A wins the first tie;
- a_gnt = b_gnt = 0;
- a_rvalid = b_rvalid = 0;
- a_err = b_err = 0;
- tw_info_en = 0 and tw_info_we = 0.
REQ-020 Reset asserted mid-burst SHALL drop the grant on that edge, and any read pending at that edge SHALL produce no rvalid.

Structure
REQ-021 A shared pom package SHALL hold TW_INFO_BITS, the entry stride (16) and the state encoding.
REQ-022 There SHALL be no sub-module; one FSM plus the muxes is sufficient.

Verification
REQ-023 The bench SHALL cover these directed scenarios:
- Single request: a_req=1 at cycle 0 -> a_gnt=1 at cycle 1; read at addr 0x20 -> tw_info_addr=0x00000020, and a_rvalid=1 one cycle later with rdata equal to the memory contents.
- Tie after reset: a_req=b_req=1 at cycle 0 -> a_gnt at cycle 1; A drops req at cycle 5 -> IDLE at cycle 6, b_gnt at cycle 7.
- Round-robin: A releases while both masters still request -> next owner is B; B releases -> next owner is A.
- Locked burst: A holds the grant for 300 cycles while b_req=1 -> b_gnt stays 0 throughout; 16 consecutive searches return 16 rvalid pulses.
- Illegal access: b_en=1 with we=FFFF while A owns the port -> tw_info_we shows only A's value, the memory is unchanged, and b_err=1 stays set until rst.
- Reset mid-burst: rst=1 during A's read -> no a_rvalid, both grants 0, errors cleared; after rst, a tie resolves to A.
